// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared FSM encoding and GAP timing for spi_cmd_sequencer.
package spi_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_e;

    localparam int unsigned GAP_CYCLES = 2;
    localparam int unsigned GAP_CNT_W  = 2;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Request queue for spi_cmd_sequencer: DEPTH entries, wrapping pointers, level count.
module spi_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    anrst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        wdata_i,
    output logic [WIDTH-1:0]        rdata_c_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok_c;
    logic             pop_ok_c;

    // Full queue ignores pushes; empty queue ignores pops.
    assign push_ok_c = push_i && (level_q != LW'(DEPTH));
    assign pop_ok_c  = pop_i && (level_q != '0);

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues SPI read/write requests and sequences command levels to an SPI master.
// Optional wait-state timeout enabled by defining SPI_CMD_SEQUENCER_TIMEOUT_EN.
module spi_cmd_sequencer
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int unsigned MOSI_DATA_WIDTH = 8,
    parameter int unsigned MISO_DATA_WIDTH = 8,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                        clk,
    input  logic                        anrst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_rd,
    input  logic [MOSI_DATA_WIDTH-1:0]  req_data,
    output logic                        spi_wr_cmd,
    output logic                        spi_rd_cmd,
    output logic [MOSI_DATA_WIDTH-1:0]  mosi_data,
    input  logic                        spi_busy,
    input  logic [MISO_DATA_WIDTH-1:0]  miso_data,
    output logic                        rsp_valid,
    output logic                        rsp_rd,
    output logic [MISO_DATA_WIDTH-1:0]  rsp_data,
    output logic                        rsp_err,
    output logic [$clog2(DEPTH):0]      queue_level
);

    localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = MOSI_DATA_WIDTH + 1;

    state_e                       state_q, state_d;
    logic                         wr_cmd_q, wr_cmd_d;
    logic                         rd_cmd_q, rd_cmd_d;
    logic                         rd_flag_q, rd_flag_d;
    logic [MOSI_DATA_WIDTH-1:0]   mosi_q, mosi_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic                         rsp_rd_q, rsp_rd_d;
    logic [MISO_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [GAP_CNT_W-1:0]         gap_q, gap_d;
    logic                         fifo_push_c;
    logic                         fifo_pop_c;
    logic [ENTRY_W-1:0]           fifo_head_c;
    logic [LVL_W-1:0]             level_c;
    logic                         tmo_hit_c;

    assign req_ready   = (level_c != LVL_W'(DEPTH));
    assign fifo_push_c = req_valid && req_ready;

    spi_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .anrst     (anrst),
        .push_i    (fifo_push_c),
        .pop_i     (fifo_pop_c),
        .wdata_i   ({req_rd, req_data}),
        .rdata_c_o (fifo_head_c),
        .level_o   (level_c)
    );

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        wr_cmd_d    = wr_cmd_q;
        rd_cmd_d    = rd_cmd_q;
        rd_flag_d   = rd_flag_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rd_d    = rsp_rd_q;
        rsp_data_d  = rsp_data_q;
        gap_d       = gap_q;
        fifo_pop_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((level_c != '0) && !spi_busy) begin
                    fifo_pop_c = 1'b1;
                    rd_flag_d  = fifo_head_c[ENTRY_W-1];
                    mosi_d     = fifo_head_c[MOSI_DATA_WIDTH-1:0];
                    wr_cmd_d   = ~fifo_head_c[ENTRY_W-1];
                    rd_cmd_d   = fifo_head_c[ENTRY_W-1];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (spi_busy) begin
                    wr_cmd_d = 1'b0;
                    rd_cmd_d = 1'b0;
                    state_d  = ST_WAIT_DONE;
                end else if (tmo_hit_c) begin
                    wr_cmd_d    = 1'b0;
                    rd_cmd_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rd_d    = rd_flag_q;
                    rsp_data_d  = '0;
                    gap_d       = '0;
                    state_d     = ST_GAP;
                end
            end
            ST_WAIT_DONE: begin
                if (!spi_busy) begin
                    rsp_valid_d = 1'b1;
                    rsp_rd_d    = rd_flag_q;
                    rsp_data_d  = rd_flag_q ? miso_data : '0;
                    gap_d       = '0;
                    state_d     = ST_GAP;
                end else if (tmo_hit_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_rd_d    = rd_flag_q;
                    rsp_data_d  = '0;
                    gap_d       = '0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_CNT_W'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state_q     <= ST_IDLE;
            wr_cmd_q    <= 1'b0;
            rd_cmd_q    <= 1'b0;
            rd_flag_q   <= 1'b0;
            mosi_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= 1'b0;
            rsp_data_q  <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_cmd_q    <= wr_cmd_d;
            rd_cmd_q    <= rd_cmd_d;
            rd_flag_q   <= rd_flag_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_data_q  <= rsp_data_d;
            gap_q       <= gap_d;
        end
    end

`ifdef SPI_CMD_SEQUENCER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rsp_err_q;

    // Counts cycles spent in the current wait state; any state change restarts it.
    always_comb begin
        tmo_d = '0;
        if ((state_d == state_q) &&
            ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE))) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    assign tmo_hit_c = ((state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE)) &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // A response leaving WAIT_BUSY, or WAIT_DONE with busy still high, is a timeout.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            tmo_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            if (rsp_valid_d) begin
                rsp_err_q <= (state_q == ST_WAIT_BUSY) || spi_busy;
            end
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign tmo_hit_c = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign spi_wr_cmd  = wr_cmd_q;
    assign spi_rd_cmd  = rd_cmd_q;
    assign mosi_data   = mosi_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_data    = rsp_data_q;
    assign queue_level = level_c;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a simple delayed-busy SPI slave model.
module tb_spi_cmd_sequencer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;
`ifdef SPI_CMD_SEQUENCER_TIMEOUT_EN
    localparam int unsigned BUSY_LEN = 10;
`else
    localparam int unsigned BUSY_LEN = 20;
`endif
    // Rise-to-rise: 4 cycles to busy, BUSY_LEN busy, 1 to sample the fall, 2 GAP.
    localparam int unsigned SPACING = BUSY_LEN + 7;

    logic                 clk = 1'b0;
    logic                 anrst = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic                 req_rd = 1'b0;
    logic [DW-1:0]        req_data = '0;
    logic                 spi_wr_cmd;
    logic                 spi_rd_cmd;
    logic [DW-1:0]        mosi_data;
    logic                 spi_busy;
    logic [DW-1:0]        miso_data = '0;
    logic                 rsp_valid;
    logic                 rsp_rd;
    logic [DW-1:0]        rsp_data;
    logic                 rsp_err;
    logic [2:0]           queue_level;

    logic                 slave_busy = 1'b0;
    logic                 force_busy = 1'b0;
    logic                 slave_en = 1'b1;
    assign spi_busy = slave_busy | force_busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    spi_cmd_sequencer #(
        .MOSI_DATA_WIDTH (DW),
        .MISO_DATA_WIDTH (DW),
        .DEPTH           (DEPTH),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk         (clk),
        .anrst       (anrst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .spi_wr_cmd  (spi_wr_cmd),
        .spi_rd_cmd  (spi_rd_cmd),
        .mosi_data   (mosi_data),
        .spi_busy    (spi_busy),
        .miso_data   (miso_data),
        .rsp_valid   (rsp_valid),
        .rsp_rd      (rsp_rd),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .queue_level (queue_level)
    );

    always #5 clk = ~clk;

    // Slave: busy rises on the 4th negedge seeing a command, lasts BUSY_LEN, returns ~mosi.
    int unsigned dly = 0;
    int unsigned blen = 0;
    logic        active = 1'b0;
    always @(negedge clk) begin
        if (!anrst) begin
            slave_busy = 1'b0;
            dly = 0;
            blen = 0;
            active = 1'b0;
        end else if (!active) begin
            if (slave_en && (spi_wr_cmd || spi_rd_cmd)) begin
                if (dly == 3) begin
                    slave_busy = 1'b1;
                    active = 1'b1;
                    dly = 0;
                    blen = 0;
                    miso_data = 8'hEE;
                end else begin
                    dly++;
                end
            end
        end else begin
            blen++;
            if (blen == BUSY_LEN) begin
                slave_busy = 1'b0;
                active = 1'b0;
                miso_data = ~mosi_data;
            end
        end
    end

    // Monitor: command-high counts, command rises, responses.
    int unsigned   cyc = 0;
    int unsigned   wr_hi = 0;
    int unsigned   rd_hi = 0;
    int unsigned   both_hi = 0;
    int unsigned   mosi_bad = 0;
    int unsigned   rsp_cnt = 0;
    logic          cmd_prev = 1'b0;
    logic          in_txn = 1'b0;
    logic [DW-1:0] txn_mosi = '0;
    logic [DW-1:0] rise_mosi_q[$];
    int unsigned   rise_cyc_q[$];
    logic [9:0]    rsp_q[$];
    always @(negedge clk) begin
        cyc++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_q.push_back({rsp_err, rsp_rd, rsp_data});
        end
        if (!anrst) begin
            cmd_prev = 1'b0;
            in_txn = 1'b0;
        end else begin
            if (spi_wr_cmd) wr_hi++;
            if (spi_rd_cmd) rd_hi++;
            if (spi_wr_cmd && spi_rd_cmd) both_hi++;
            if ((spi_wr_cmd || spi_rd_cmd) && !cmd_prev) begin
                rise_mosi_q.push_back(mosi_data);
                rise_cyc_q.push_back(cyc);
                in_txn = 1'b1;
                txn_mosi = mosi_data;
            end else if (in_txn && (mosi_data != txn_mosi)) begin
                mosi_bad++;
            end
            if (rsp_valid) in_txn = 1'b0;
            cmd_prev = spi_wr_cmd || spi_rd_cmd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_req(input logic rd, input logic [DW-1:0] d);
        int unsigned t = 0;
        while (!req_ready && t < 200) begin
            step();
            t++;
        end
        req_valid = 1'b1;
        req_rd = rd;
        req_data = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int unsigned target, input int unsigned budget, input string name);
        int unsigned t = 0;
        while (rsp_cnt < target && t < budget) begin
            step();
            t++;
        end
        check(name, rsp_cnt, target);
    endtask

    typedef struct {
        logic          rd;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        int unsigned   exp_wr;
        int unsigned   exp_rd;
    } vec_t;

    initial begin
        vec_t          vecs[5];
        logic          q_rd[5];
        logic [DW-1:0] q_wd[5];
        logic [DW-1:0] q_exp[5];
        int unsigned   w0, rr0, r0, n0, n1, t;

        vecs[0] = '{1'b0, 8'hA5, 8'h00, 4, 0};
        vecs[1] = '{1'b1, 8'hC3, 8'h3C, 0, 4};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 0, 4};
        vecs[3] = '{1'b0, 8'hFF, 8'h00, 4, 0};
        vecs[4] = '{1'b1, 8'h7E, 8'h81, 0, 4};
        q_rd  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        q_wd  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        q_exp = '{8'h00, 8'hDD, 8'h00, 8'hBB, 8'hAA};

        // Reset state.
        repeat (3) step();
        check("rst_wr_cmd", spi_wr_cmd, 0);
        check("rst_rd_cmd", spi_rd_cmd, 0);
        check("rst_mosi", mosi_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rd", rsp_rd, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_level", queue_level, 0);
        check("rst_ready", req_ready, 1);
        anrst = 1'b1;
        step();

        // Single transactions from the vector table.
        for (int i = 0; i < 5; i++) begin
            w0 = wr_hi;
            rr0 = rd_hi;
            r0 = rsp_cnt;
            n0 = rise_mosi_q.size();
            push_req(vecs[i].rd, vecs[i].wdata);
            wait_rsp(r0 + 1, SPACING + 20, $sformatf("v%0d_rsp_seen", i));
            repeat (6) step();
            check($sformatf("v%0d_one_pulse", i), rsp_cnt, r0 + 1);
            check($sformatf("v%0d_rsp_rd", i), rsp_q[r0][8], vecs[i].rd);
            check($sformatf("v%0d_rsp_data", i), rsp_q[r0][7:0], vecs[i].exp_data);
            check($sformatf("v%0d_rsp_err", i), rsp_q[r0][9], 0);
            check($sformatf("v%0d_wr_hi", i), wr_hi - w0, vecs[i].exp_wr);
            check($sformatf("v%0d_rd_hi", i), rd_hi - rr0, vecs[i].exp_rd);
            check($sformatf("v%0d_rises", i), rise_mosi_q.size(), n0 + 1);
            if (rise_mosi_q.size() > n0)
                check($sformatf("v%0d_mosi", i), rise_mosi_q[n0], vecs[i].wdata);
            check($sformatf("v%0d_hold_rd", i), rsp_rd, vecs[i].rd);
            check($sformatf("v%0d_hold_data", i), rsp_data, vecs[i].exp_data);
        end

        // Fill the queue while the master is busy, then drain in order.
        force_busy = 1'b1;
        step();
        r0 = rsp_cnt;
        n0 = rise_mosi_q.size();
        for (int i = 0; i < 4; i++) push_req(q_rd[i], q_wd[i]);
        check("full_level", queue_level, 4);
        check("full_ready", req_ready, 0);
        req_valid = 1'b1;
        req_rd = q_rd[4];
        req_data = q_wd[4];
        repeat (3) step();
        check("fifth_held_level", queue_level, 4);
        check("fifth_held_ready", req_ready, 0);
        check("stalled_no_issue", rise_mosi_q.size(), n0);
        force_busy = 1'b0;
        t = 0;
        while (!req_ready && t < 50) begin
            step();
            t++;
        end
        check("fifth_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        wait_rsp(r0 + 5, 5 * (SPACING + 10), "queue_rsp_seen");
        repeat (4) step();
        check("queue_rises", rise_mosi_q.size(), n0 + 5);
        for (int i = 0; i < 5; i++) begin
            if (rsp_q.size() > r0 + i) begin
                check($sformatf("q%0d_rsp_rd", i), rsp_q[r0 + i][8], q_rd[i]);
                check($sformatf("q%0d_rsp_data", i), rsp_q[r0 + i][7:0], q_exp[i]);
            end
            if (rise_mosi_q.size() > n0 + i)
                check($sformatf("q%0d_mosi", i), rise_mosi_q[n0 + i], q_wd[i]);
            if (i > 0 && rise_cyc_q.size() > n0 + i)
                check($sformatf("q%0d_spacing", i),
                      rise_cyc_q[n0 + i] - rise_cyc_q[n0 + i - 1], SPACING);
        end

        // Reset during WAIT_DONE with two requests queued.
        push_req(1'b0, 8'h12);
        push_req(1'b1, 8'h34);
        push_req(1'b0, 8'h56);
        t = 0;
        while (!(spi_busy && !spi_wr_cmd && !spi_rd_cmd) && t < 60) begin
            step();
            t++;
        end
        check("mid_reached_wait_done", spi_busy, 1);
        check("mid_level", queue_level, 2);
        anrst = 1'b0;
        #1;
        check("mid_rst_wr_cmd", spi_wr_cmd, 0);
        check("mid_rst_rd_cmd", spi_rd_cmd, 0);
        check("mid_rst_mosi", mosi_data, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_rd", rsp_rd, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        check("mid_rst_level", queue_level, 0);
        check("mid_rst_ready", req_ready, 1);
        r0 = rsp_cnt;
        repeat (3) step();
        anrst = 1'b1;
        n1 = rise_mosi_q.size();
        repeat (40) step();
        check("post_rst_no_rsp", rsp_cnt, r0);
        check("post_rst_no_issue", rise_mosi_q.size(), n1);
        check("post_rst_level", queue_level, 0);
        check("post_rst_ready", req_ready, 1);

`ifdef SPI_CMD_SEQUENCER_TIMEOUT_EN
        // Busy never rises: command held ISSUE + TMO wait cycles, then error response.
        slave_en = 1'b0;
        w0 = wr_hi;
        r0 = rsp_cnt;
        push_req(1'b0, 8'h5A);
        wait_rsp(r0 + 1, TMO + 30, "tmo_rsp_seen");
        repeat (4) step();
        check("tmo_one_pulse", rsp_cnt, r0 + 1);
        check("tmo_wr_hi", wr_hi - w0, TMO + 1);
        check("tmo_rsp_err", rsp_q[r0][9], 1);
        check("tmo_rsp_data", rsp_q[r0][7:0], 0);
        check("tmo_cmd_low", spi_wr_cmd, 0);
        slave_en = 1'b1;
        r0 = rsp_cnt;
        push_req(1'b1, 8'h96);
        wait_rsp(r0 + 1, SPACING + 20, "after_tmo_rsp_seen");
        repeat (4) step();
        check("after_tmo_err", rsp_q[r0][9], 0);
        check("after_tmo_rd", rsp_q[r0][8], 1);
        check("after_tmo_data", rsp_q[r0][7:0], 8'h69);
`endif

        check("never_both_cmds", both_hi, 0);
        check("mosi_stable", mosi_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

endmodule
